// File: rtl/gen_mux_if.sv
// gen_mux_if: capture/select inputs and registered results of gen_mux.
// The 'par' signal exists only when GEN_MUX_PARITY_EN is defined.
interface gen_mux_if #(
    parameter int DATA_W = 16,
    parameter int SEL_W  = 4,
    parameter int NIB_W  = 4
);
    logic              en;
    logic [DATA_W-1:0] data;
    logic [SEL_W-1:0]  select;
    logic              out;
    logic [NIB_W-1:0]  f;
    logic              out_valid;
`ifdef GEN_MUX_PARITY_EN
    logic              par;

    modport master (output en, data, select, input out, f, out_valid, par);
    modport slave  (input en, data, select, output out, f, out_valid, par);
`else
    modport master (output en, data, select, input out, f, out_valid);
    modport slave  (input en, data, select, output out, f, out_valid);
`endif
endinterface

// File: rtl/gen_mux.sv
// gen_mux: registered 16:1 bit mux tree plus select-steered nibble output.
// Optional macro GEN_MUX_PARITY_EN adds a registered XOR-reduction output 'par'.
module gen_mux #(
    parameter int DATA_W = 16,
    parameter int SEL_W  = 4,
    parameter int NIB_W  = 4
) (
    input  logic     clk,
    input  logic     rst_n,
    gen_mux_if.slave bus
);

    logic             w_bit;
    logic [NIB_W-1:0] w_nib;
    logic             r_out;
    logic [NIB_W-1:0] r_f;
    logic             r_valid;

    // Each level halves the candidate set; level k is steered by select[k].
    genvar k, i;
    generate
        for (k = 0; k < SEL_W; k++) begin : g_lvl
            localparam int N = DATA_W >> (k + 1);
            logic [N-1:0] w_node;
            for (i = 0; i < N; i++) begin : g_mux
                if (k == 0) begin : g_leaf
                    assign w_node[i] = bus.select[k] ? bus.data[2*i+1] : bus.data[2*i];
                end else begin : g_inner
                    assign w_node[i] = bus.select[k] ? g_lvl[k-1].w_node[2*i+1]
                                                     : g_lvl[k-1].w_node[2*i];
                end
            end
        end
    endgenerate

    assign w_bit = g_lvl[SEL_W-1].w_node[0];

    // Select MSB set picks the low nibble, clear picks the high nibble.
    assign w_nib = bus.select[SEL_W-1] ? bus.data[NIB_W-1:0]
                                       : bus.data[DATA_W-1 -: NIB_W];

    // Output registers: reset clears, enable captures, otherwise hold.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out   <= 1'b0;
            r_f     <= {NIB_W{1'b0}};
            r_valid <= 1'b0;
        end else begin
            r_valid <= bus.en;
            if (bus.en) begin
                r_out <= w_bit;
                r_f   <= w_nib;
            end else begin
                r_out <= r_out;
                r_f   <= r_f;
            end
        end
    end

    assign bus.out       = r_out;
    assign bus.f         = r_f;
    assign bus.out_valid = r_valid;

`ifdef GEN_MUX_PARITY_EN
    logic r_par;

    // Parity register follows the same capture/hold/reset rules as out.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_par <= 1'b0;
        end else if (bus.en) begin
            r_par <= ^bus.data;
        end else begin
            r_par <= r_par;
        end
    end

    assign bus.par = r_par;
`endif

endmodule

// File: tb/tb_gen_mux.sv
// tb_gen_mux: scoreboard-driven bench for gen_mux; expected results are queued
// when stimulus is applied and popped when the registered outputs are sampled.
module tb_gen_mux;

    typedef struct packed {
        logic       o;
        logic [3:0] f;
        logic       v;
        logic       p;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;
    exp_t sb_q[$];
    exp_t m_state;

    gen_mux_if #(.DATA_W(16), .SEL_W(4), .NIB_W(4)) bus ();

    gen_mux #(.DATA_W(16), .SEL_W(4), .NIB_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: advances the bench's own copy of the registers.
    task automatic model_push(input logic rst, input logic en, input logic [15:0] d,
                              input logic [3:0] s);
        logic [15:0] sh;
        sh = d >> s;
        if (!rst) begin
            m_state = '0;
        end else begin
            m_state.v = en;
            if (en) begin
                m_state.o = sh[0];
                m_state.f = s[3] ? d[3:0] : d[15:12];
                m_state.p = ^d;
            end
        end
        sb_q.push_back(m_state);
    endtask

    // Drive one cycle at the falling edge, sample just after the rising edge.
    task automatic apply(input logic rst, input logic en, input logic [15:0] d,
                         input logic [3:0] s);
        @(negedge clk);
        rst_n      = rst;
        bus.en     = en;
        bus.data   = d;
        bus.select = s;
        model_push(rst, en, d, s);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        exp_t e;
        apply(1'b0, 1'b1, 16'hFFFF, 4'b1111);
        e = sb_q.pop_front();
        n_cmp++;
        if (bus.out !== e.o || bus.f !== e.f || bus.out_valid !== e.v) begin
            n_err++;
            $display("FAIL reset got out=%b f=%h v=%b want out=%b f=%h v=%b",
                     bus.out, bus.f, bus.out_valid, e.o, e.f, e.v);
        end
        n_cmp++;
        if ({bus.out, bus.f, bus.out_valid} !== 6'b0) begin
            n_err++;
            $display("FAIL reset_zero got %b want 000000", {bus.out, bus.f, bus.out_valid});
        end
    endtask

    task automatic test_bit_sweep();
        logic [3:0] sels [6] = '{4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b1111};
        logic       bits [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        exp_t e;
        for (int j = 0; j < 6; j++) begin
            apply(1'b1, 1'b1, 16'hA3F1, sels[j]);
            e = sb_q.pop_front();
            n_cmp++;
            if (bus.out !== bits[j] || bus.out !== e.o) begin
                n_err++;
                $display("FAIL sweep_out sel=%b got=%b want=%b", sels[j], bus.out, bits[j]);
            end
            n_cmp++;
            if (bus.f !== e.f || bus.out_valid !== e.v) begin
                n_err++;
                $display("FAIL sweep_fv sel=%b got f=%h v=%b want f=%h v=%b",
                         sels[j], bus.f, bus.out_valid, e.f, e.v);
            end
        end
    endtask

    task automatic test_nibble();
        logic [3:0] sels [2] = '{4'b1001, 4'b0001};
        logic [3:0] nibs [2] = '{4'h1, 4'hA};
        exp_t e;
        for (int j = 0; j < 2; j++) begin
            apply(1'b1, 1'b1, 16'hA3F1, sels[j]);
            e = sb_q.pop_front();
            n_cmp++;
            if (bus.f !== nibs[j] || bus.f !== e.f) begin
                n_err++;
                $display("FAIL nibble sel=%b got=%h want=%h", sels[j], bus.f, nibs[j]);
            end
        end
    endtask

    task automatic test_hold();
        exp_t e;
        apply(1'b1, 1'b1, 16'hA3F1, 4'b0000);
        e = sb_q.pop_front();
        n_cmp++;
        if (bus.out !== 1'b1 || bus.f !== 4'hA || bus.out_valid !== 1'b1) begin
            n_err++;
            $display("FAIL hold_capture got out=%b f=%h v=%b want out=1 f=a v=1",
                     bus.out, bus.f, bus.out_valid);
        end
        for (int j = 0; j < 2; j++) begin
            apply(1'b1, 1'b0, 16'h0000, 4'b0101);
            e = sb_q.pop_front();
            n_cmp++;
            if (bus.out !== e.o || bus.f !== e.f || bus.out_valid !== e.v ||
                bus.out !== 1'b1 || bus.f !== 4'hA || bus.out_valid !== 1'b0) begin
                n_err++;
                $display("FAIL hold cyc=%0d got out=%b f=%h v=%b want out=1 f=a v=0",
                         j, bus.out, bus.f, bus.out_valid);
            end
        end
    endtask

    task automatic test_reset_priority();
        exp_t e;
        apply(1'b1, 1'b1, 16'hFFFF, 4'b0111);
        void'(sb_q.pop_front());
        apply(1'b0, 1'b1, 16'hFFFF, 4'b1111);
        e = sb_q.pop_front();
        n_cmp++;
        if ({bus.out, bus.f, bus.out_valid} !== {e.o, e.f, e.v} || bus.out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_prio got out=%b f=%h v=%b want all zero",
                     bus.out, bus.f, bus.out_valid);
        end
        apply(1'b1, 1'b0, 16'hFFFF, 4'b1111);
        e = sb_q.pop_front();
        n_cmp++;
        if ({bus.out, bus.f, bus.out_valid} !== 6'b0) begin
            n_err++;
            $display("FAIL reset_release got out=%b f=%h v=%b want all zero",
                     bus.out, bus.f, bus.out_valid);
        end
    endtask

    task automatic test_back_to_back();
        exp_t        e;
        logic [15:0] d;
        logic [3:0]  s;
        logic        en;
        for (int j = 0; j < 48; j++) begin
            d  = 16'($urandom());
            s  = 4'($urandom_range(0, 15));
            en = (j < 16) ? 1'b1 : 1'($urandom_range(0, 1));
            apply(1'b1, en, d, s);
            e = sb_q.pop_front();
            n_cmp++;
            if (bus.out !== e.o || bus.f !== e.f || bus.out_valid !== e.v) begin
                n_err++;
                $display("FAIL b2b j=%0d d=%h s=%b en=%b got out=%b f=%h v=%b want out=%b f=%h v=%b",
                         j, d, s, en, bus.out, bus.f, bus.out_valid, e.o, e.f, e.v);
            end
`ifdef GEN_MUX_PARITY_EN
            n_cmp++;
            if (bus.par !== e.p) begin
                n_err++;
                $display("FAIL b2b_par j=%0d got=%b want=%b", j, bus.par, e.p);
            end
`endif
        end
    endtask

`ifdef GEN_MUX_PARITY_EN
    task automatic test_parity();
        logic [15:0] ds   [2] = '{16'hA3F1, 16'h0003};
        logic        pars [2] = '{1'b1, 1'b0};
        exp_t e;
        for (int j = 0; j < 2; j++) begin
            apply(1'b1, 1'b1, ds[j], 4'b0000);
            e = sb_q.pop_front();
            n_cmp++;
            if (bus.par !== pars[j] || bus.par !== e.p) begin
                n_err++;
                $display("FAIL parity d=%h got=%b want=%b", ds[j], bus.par, pars[j]);
            end
        end
    endtask
`endif

    initial begin
        n_cmp      = 0;
        n_err      = 0;
        m_state    = '0;
        rst_n      = 1'b0;
        bus.en     = 1'b0;
        bus.data   = 16'h0000;
        bus.select = 4'b0000;
        test_reset();
        test_bit_sweep();
        test_nibble();
        test_hold();
        test_reset_priority();
        test_back_to_back();
`ifdef GEN_MUX_PARITY_EN
        test_parity();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
